// File: rtl/fp16_add_issue.sv
// Operand-issue / result-collection wrapper around the fixed-latency FP16 adder.
// Credit-based issue guarantees every accepted pair already owns an output FIFO slot.
module fp16_add_issue #(
   parameter int unsigned ADD_LATENCY = 4,
   parameter int unsigned OUT_DEPTH   = 8
) (
   input  logic        clk_59,
   input  logic        rst_59,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   input  logic [15:0] add_c,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sum,
   output logic        busy
);
   localparam int unsigned DW = 16;
   localparam int unsigned CW = $clog2(OUT_DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam int unsigned PW = $clog2(OUT_DEPTH);

   logic [DW-1:0]        add_a_q, add_a_d;
   logic [DW-1:0]        add_b_q, add_b_d;
   logic [ADD_LATENCY:0] tag_q, tag_d;
   logic [ADD_LATENCY:0] zflag_q, zflag_d;
   logic [CW-1:0]        inflight_q, inflight_d;
   logic [CW-1:0]        count_q, count_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [DW-1:0]        mem_q [OUT_DEPTH];

   logic          accept;
   logic          capture;
   logic          pop;
   logic [DW-1:0] wr_data;
   logic [SW-1:0] credits_used;

   // Credits are derived from registered counters only.
   assign credits_used = SW'(inflight_q) + SW'(count_q);
   assign in_ready     = !rst_59 && (credits_used < SW'(OUT_DEPTH));
   assign out_valid    = (count_q != '0);
   assign out_sum      = out_valid ? mem_q[rd_ptr_q] : '0;
   assign busy         = (inflight_q != '0) || out_valid;
   assign add_a        = add_a_q;
   assign add_b        = add_b_q;

   assign accept  = in_valid && in_ready;
   assign capture = tag_q[ADD_LATENCY];
   assign pop     = out_valid && out_ready;

   always_comb begin
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      tag_d      = {tag_q[ADD_LATENCY-1:0], accept};
      zflag_d    = {zflag_q[ADD_LATENCY-1:0], (in_a == 16'h0000) && (in_b == 16'h0000)};
      inflight_d = inflight_q + CW'(accept) - CW'(capture);
      count_d    = count_q + CW'(capture) - CW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(capture);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      // The adder's own zero detect sees its current inputs, so force zero from the aligned flag.
      wr_data    = zflag_q[ADD_LATENCY] ? '0 : add_c;
      if (accept) begin
         add_a_d = in_a;
         add_b_d = in_b;
      end
   end

   always_ff @(posedge clk_59) begin
      if (rst_59) begin
         add_a_q    <= '0;
         add_b_q    <= '0;
         tag_q      <= '0;
         zflag_q    <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         tag_q      <= tag_d;
         zflag_q    <= zflag_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Result storage; contents are only observable through out_sum when out_valid.
   always_ff @(posedge clk_59) begin
      if (!rst_59 && capture) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk_59) begin
      if (!rst_59) begin
         assert (!(capture && (count_q == CW'(OUT_DEPTH))));
      end
   end
endmodule

// File: doc/fp16_add_issue.md
Name: fp16_add_issue

Overview:
- Operand-issue and result-collection wrapper for the 4-stage pipelined FP16 adder `fpadder`.
- Accepts operand pairs on a valid/ready stream, drives the adder's A/B inputs, and tracks each issue through the fixed adder latency with a tag shift register.
- Captures adder results into an output FIFO presented on a valid/ready stream.
- Credit-based issue: the adder cannot stall, so a new operand pair is accepted only when an output FIFO slot is already reserved for its result.

Parameters:
- ADD_LATENCY, 4: edges from the adder's A/B change to a valid C output (adder pipeline depth).
- OUT_DEPTH, 8: output FIFO entries. Power of 2, at least 2. Also the total credit count.

Ports:
- clk_59  in  1  clock; all state updates on rising edge.
- rst_59  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  16  FP16 operand A.
- in_b  in  16  FP16 operand B.
- add_a  out  16  to adder input A (registered).
- add_b  out  16  to adder input B (registered).
- add_c  in  16  from adder output C.
- out_valid  out  1  result available at FIFO head.
- out_ready  in  1  consumer takes result.
- out_sum  out  16  FP16 result at FIFO head.
- busy  out  1  any operation in flight or buffered.

Behaviour:
- Reset (rst_59 high at an edge):
  - Counters, FIFO pointers and tag/zero shift registers cleared; in-flight operations discarded.
  - add_a = add_b = 16'h0000.
  - out_valid = 0, out_sum = 16'h0000, busy = 0.
  - in_ready = 0 while rst_59 is high; 1 in the first cycle after release.
- Accept: an edge with in_valid && in_ready.
  - add_a <= in_a and add_b <= in_b at that edge (E0).
  - Without an accept, add_a/add_b hold their previous values.
- Tag pipeline: shift register tag[0..ADD_LATENCY], one bit per edge.
  - tag[0] <= accept; tag[k] <= tag[k-1].
- Zero flag: zflag[0..ADD_LATENCY] shifts in parallel with the tags.
  - zflag[0] <= (in_a == 16'h0000 && in_b == 16'h0000).
  - Only +0 counts as zero; 16'h8000 does not.
- Capture: at any edge where tag[ADD_LATENCY] == 1 (edge E0 + ADD_LATENCY + 1), write one entry to the FIFO.
  - Written value is 16'h0000 if zflag[ADD_LATENCY] == 1, otherwise add_c.
  - The adder's own zero detect looks at its current inputs, not the delayed ones, so the zero result must come from this block's aligned flag.
- Latency: out_valid rises ADD_LATENCY + 1 cycles after the accept edge, given an empty FIFO.
  - Default: accept at edge 0, out_valid high after edge 5.
- Ordering and throughput: results leave in accept order. Sustained throughput is 1 per cycle when out_ready is held high.
- Credits:
  - inflight: counter incremented on accept, decremented on capture. Both on the same edge leaves it unchanged.
  - count: FIFO occupancy, 0..OUT_DEPTH.
  - in_ready = !rst_59 && (inflight + count) < OUT_DEPTH. Driven from registered state only, with no combinational path from out_ready or in_valid.
  - A pop frees a credit visible in the cycle after the pop edge.
  - Counter width: clog2(OUT_DEPTH + 1).
- FIFO:
  - Circular buffer; read and write pointers wrap modulo OUT_DEPTH.
  - Pop on an edge with out_valid && out_ready.
  - out_valid = (count != 0).
  - out_sum = head entry when out_valid, else 16'h0000.
  - Write and pop on the same edge: count unchanged, both pointers advance.
  - Write into an empty FIFO is visible in the next cycle; there is no same-cycle bypass.
  - Overflow is impossible by construction. A write while count == OUT_DEPTH is an assertion failure.
  - Pop while empty is ignored.
- busy = (inflight != 0) || (count != 0).

Test Plan:
1. Reset, then accept in_a=16'h3C00, in_b=16'h3C00 at edge 0, out_ready=1.
   -> out_valid high exactly after edge 5 with out_sum=16'h4000 for one cycle; busy then drops.
2. Accept 16'h4000 + 16'hBC00.
   -> out_sum=16'h3C00 after ADD_LATENCY + 1 cycles.
3. Accept 16'h3C00+16'h3C00 then 16'h0000+16'h0000 back-to-back.
   -> results 16'h4000 then 16'h0000 on consecutive cycles. Repeat with 16'h8000+16'h0000 and confirm no zero override.
4. out_ready=1, in_valid held high for 20 pairs.
   -> in_ready never drops; 20 results in order, one per cycle, the first 5 cycles after the first accept.
5. out_ready=0, in_valid held high with 12 pairs.
   -> exactly 8 accepted, then in_ready=0; no result lost.
   Then raise out_ready -> 8 results drain in order; in_ready rises the cycle after the first pop; remaining 4 pairs complete.
6. Accept 3 pairs, assert rst_59 for 1 cycle after edge 2.
   -> no out_valid afterwards, busy=0, in_ready=1 the cycle after release, add_a=add_b=16'h0000; next single op completes normally.
